// File: rtl/uart_receiver_if.sv
// Serial receive interface: line and tick in, received word and status pulses out.
// The parity_err signal exists only when UART_RX_PARITY_EN is defined.
interface uart_receiver_if #(
  parameter int DATA_BITS = 8
);
  logic                 s_tick;
  logic                 rx;
  logic [DATA_BITS-1:0] rx_dout;
  logic                 rx_done_tick;
  logic                 frame_err;
  logic                 busy;
`ifdef UART_RX_PARITY_EN
  logic                 parity_err;

  modport master (output s_tick, rx,
                  input  rx_dout, rx_done_tick, frame_err, busy, parity_err);
  modport slave  (input  s_tick, rx,
                  output rx_dout, rx_done_tick, frame_err, busy, parity_err);
`else
  modport master (output s_tick, rx,
                  input  rx_dout, rx_done_tick, frame_err, busy);
  modport slave  (input  s_tick, rx,
                  output rx_dout, rx_done_tick, frame_err, busy);
`endif
endinterface

// File: rtl/uart_receiver.sv
// 16x-oversampled UART receiver, LSB first, configurable data and stop length.
// Optional parity stage enabled by defining UART_RX_PARITY_EN.
module uart_receiver #(
  parameter int DATA_BITS      = 8,
  parameter int STOP_BIT_TICKS = 16,
  parameter int PARITY_ODD     = 0
) (
  input logic           clk,
  input logic           reset_n,
  uart_receiver_if.slave rx_if
);

  localparam int SW = ($clog2(STOP_BIT_TICKS) > 4) ? $clog2(STOP_BIT_TICKS) : 4;
  localparam int NW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [SW-1:0] S_MID  = SW'(7);
  localparam logic [SW-1:0] S_BIT  = SW'(15);
  localparam logic [SW-1:0] S_STOP = SW'(STOP_BIT_TICKS - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t               state_q;
  logic [1:0]           rx_sync_q;
  logic [SW-1:0]        s_q;
  logic [NW-1:0]        n_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic [DATA_BITS-1:0] dout_q;
  logic                 done_q;
  logic                 ferr_q;
  logic                 rx_s;
`ifdef UART_RX_PARITY_EN
  localparam logic PAR_SENSE = PARITY_ODD[0];
  logic                 par_q;
  logic                 perr_q;
`endif

  assign rx_s = rx_sync_q[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      rx_sync_q <= 2'b11;
      s_q       <= '0;
      n_q       <= '0;
      shreg_q   <= '0;
      dout_q    <= '0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q     <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      rx_sync_q <= {rx_sync_q[0], rx_if.rx};
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q    <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_q <= START;
            s_q     <= '0;
          end
        end
        // Start bit is re-checked at its midpoint so short glitches are dropped.
        START: begin
          if (rx_if.s_tick) begin
            if (s_q == S_MID) begin
              if (!rx_s) begin
                state_q <= DATA;
                s_q     <= '0;
                n_q     <= '0;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              s_q <= s_q + 1'b1;
            end
          end
        end
        DATA: begin
          if (rx_if.s_tick) begin
            if (s_q == S_BIT) begin
              s_q     <= '0;
              shreg_q <= {rx_s, shreg_q[DATA_BITS-1:1]};
              if (n_q == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                state_q <= PARITY;
`else
                state_q <= STOP;
`endif
              end else begin
                n_q <= n_q + 1'b1;
              end
            end else begin
              s_q <= s_q + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (rx_if.s_tick) begin
            if (s_q == S_BIT) begin
              par_q   <= rx_s;
              s_q     <= '0;
              state_q <= STOP;
            end else begin
              s_q <= s_q + 1'b1;
            end
          end
        end
`endif
        // The word is published even when the stop bit is bad; frame_err flags it.
        STOP: begin
          if (rx_if.s_tick) begin
            if (s_q == S_STOP) begin
              dout_q  <= shreg_q;
              done_q  <= 1'b1;
              ferr_q  <= !rx_s;
`ifdef UART_RX_PARITY_EN
              perr_q  <= ((^shreg_q) ^ par_q) != PAR_SENSE;
`endif
              s_q     <= '0;
              state_q <= IDLE;
            end else begin
              s_q <= s_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rx_if.rx_dout      = dout_q;
  assign rx_if.rx_done_tick = done_q;
  assign rx_if.frame_err    = ferr_q;
  assign rx_if.busy         = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign rx_if.parity_err   = perr_q;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: 8 data bits, 16 ticks per bit, s_tick every 4 clocks.
module tb_uart_receiver;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [1:0] tdiv = 2'd0;

  uart_receiver_if #(.DATA_BITS(8)) u_if ();

  uart_receiver #(
    .DATA_BITS(8),
    .STOP_BIT_TICKS(16),
    .PARITY_ODD(0)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .rx_if(u_if.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) tdiv <= tdiv + 2'd1;
  assign u_if.s_tick = (tdiv == 2'd3);

  int n_assert = 0;
  int n_fail   = 0;

  int         done_cnt = 0;
  int         ferr_cnt = 0;
  logic [7:0] done_data [8];
  logic       done_ferr [8];
  logic       done_perr [8];

  // Monitor: record every completion and any frame_err pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (u_if.frame_err) ferr_cnt <= ferr_cnt + 1;
    if (u_if.rx_done_tick) begin
      if (done_cnt < 8) begin
        done_data[done_cnt] <= u_if.rx_dout;
        done_ferr[done_cnt] <= u_if.frame_err;
`ifdef UART_RX_PARITY_EN
        done_perr[done_cnt] <= u_if.parity_err;
`else
        done_perr[done_cnt] <= 1'b0;
`endif
      end
      done_cnt <= done_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ticks(input int k);
    repeat (k) begin
      @(negedge clk);
      while (!u_if.s_tick) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v, input int stop_ticks,
                            input logic par_flip);
    u_if.rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      u_if.rx = d[i];
      wait_ticks(16);
    end
`ifdef UART_RX_PARITY_EN
    u_if.rx = (^d) ^ 1'b0 ^ par_flip;
    wait_ticks(16);
`else
    if (par_flip) wait_ticks(0);
`endif
    u_if.rx = stop_v;
    wait_ticks(stop_ticks);
    u_if.rx = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    u_if.rx = 1'b1;
    reset_n = 1'b0;
    repeat (4) @(negedge clk);
    check("reset_dout", 32'(u_if.rx_dout), 32'h0);
    check("reset_done", 32'(u_if.rx_done_tick), 32'h0);
    check("reset_ferr", 32'(u_if.frame_err), 32'h0);
    check("reset_busy", 32'(u_if.busy), 32'h0);
    reset_n = 1'b1;
    wait_ticks(8);

    // 0xA5 clean frame
    base = done_cnt;
    send_frame(8'hA5, 1'b1, 16, 1'b0);
    wait_ticks(16);
    check("a5_count", 32'(done_cnt - base), 32'd1);
    check("a5_data", 32'(done_data[base]), 32'hA5);
    check("a5_ferr", 32'(done_ferr[base]), 32'h0);
    check("a5_dout_hold", 32'(u_if.rx_dout), 32'hA5);

    // Short start glitch
    base = done_cnt;
    u_if.rx = 1'b0;
    wait_ticks(4);
    check("glitch_busy_mid", 32'(u_if.busy), 32'h1);
    u_if.rx = 1'b1;
    wait_ticks(8);
    check("glitch_busy_after", 32'(u_if.busy), 32'h0);
    check("glitch_count", 32'(done_cnt - base), 32'd0);
    check("glitch_dout", 32'(u_if.rx_dout), 32'hA5);
    wait_ticks(8);

    // 0x3C with stop bit low
    base = done_cnt;
    send_frame(8'h3C, 1'b0, 9, 1'b0);
    wait_ticks(32);
    check("ferr_count", 32'(done_cnt - base), 32'd1);
    check("ferr_data", 32'(done_data[base]), 32'h3C);
    check("ferr_flag", 32'(done_ferr[base]), 32'h1);
    check("ferr_dout", 32'(u_if.rx_dout), 32'h3C);

    // Back-to-back 0x00 then 0xFF
    base = done_cnt;
    send_frame(8'h00, 1'b1, 16, 1'b0);
    send_frame(8'hFF, 1'b1, 16, 1'b0);
    wait_ticks(16);
    check("b2b_count", 32'(done_cnt - base), 32'd2);
    check("b2b_first", 32'(done_data[base]), 32'h00);
    check("b2b_second", 32'(done_data[base+1]), 32'hFF);
    check("b2b_ferr", 32'({done_ferr[base], done_ferr[base+1]}), 32'h0);

    // Reset during data bit 3
    base = done_cnt;
    u_if.rx = 1'b0;
    wait_ticks(16);
    u_if.rx = 1'b1; wait_ticks(16);
    u_if.rx = 1'b0; wait_ticks(16);
    u_if.rx = 1'b1; wait_ticks(16);
    u_if.rx = 1'b1; wait_ticks(8);
    reset_n = 1'b0;
    u_if.rx = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_dout", 32'(u_if.rx_dout), 32'h0);
    check("midrst_busy", 32'(u_if.busy), 32'h0);
    check("midrst_done", 32'(u_if.rx_done_tick), 32'h0);
    check("midrst_ferr", 32'(u_if.frame_err), 32'h0);
    reset_n = 1'b1;
    wait_ticks(200);
    check("midrst_no_done", 32'(done_cnt - base), 32'd0);
    check("midrst_idle", 32'(u_if.busy), 32'h0);
    send_frame(8'h5A, 1'b1, 16, 1'b0);
    wait_ticks(16);
    check("5a_count", 32'(done_cnt - base), 32'd1);
    check("5a_data", 32'(done_data[base]), 32'h5A);
    check("5a_ferr", 32'(done_ferr[base]), 32'h0);
    check("ferr_total", 32'(ferr_cnt), 32'd1);

`ifdef UART_RX_PARITY_EN
    // 0x07 has odd weight: even-parity bit 1 is correct, bit 0 is an error
    base = done_cnt;
    send_frame(8'h07, 1'b1, 16, 1'b1);
    wait_ticks(16);
    send_frame(8'h07, 1'b1, 16, 1'b0);
    wait_ticks(16);
    check("par_count", 32'(done_cnt - base), 32'd2);
    check("par_bad", 32'(done_perr[base]), 32'h1);
    check("par_good", 32'(done_perr[base+1]), 32'h0);
    check("par_data", 32'(done_data[base+1]), 32'h07);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, number of data bits per frame, LSB first.
REQ-002 SHALL have parameter STOP_BIT_TICKS, default 16, oversample ticks in the stop bit (16/24/32 for 1/1.5/2 stop bits).
REQ-003 SHALL have parameter PARITY_ODD, default 0, parity sense (0 even, 1 odd), used only when UART_RX_PARITY_EN is defined.
REQ-004 SHALL have clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have reset_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have s_tick  input  1  16x-baud oversample enable, one clk cycle wide.
REQ-007 SHALL have rx  input  1  asynchronous serial line, idle high.
REQ-008 SHALL have rx_dout  output  DATA_BITS  last received data word.
REQ-009 SHALL have rx_done_tick  output  1  one-cycle pulse, frame complete.
REQ-010 SHALL have frame_err  output  1  one-cycle pulse with rx_done_tick when stop bit sampled low.
REQ-011 SHALL have busy  output  1  high whenever FSM not in IDLE.
REQ-012 SHALL have parity_err  output  1  one-cycle pulse with rx_done_tick on parity mismatch, present only when UART_RX_PARITY_EN is defined.

Function
REQ-013 SHALL pass rx through a 2-flop synchronizer (reset value 1); FSM uses only the synchronized value rx_s.
REQ-014 SHALL implement states IDLE, START, DATA, PARITY (macro only), STOP; tick counter s and bit counter n advance only on s_tick; all state holds without s_tick.
REQ-015 SHALL, in IDLE, on rx_s==0 go to START with s=0.
REQ-016 SHALL, in START on s_tick with s==7, go to DATA with s=0, n=0 if rx_s==0, else return to IDLE with no output pulse (glitch reject); otherwise increment s.
REQ-017 SHALL, in DATA on s_tick with s==15, set s=0, shift rx_s into shift-register MSB (right shift), go to STOP (PARITY if macro) when n==DATA_BITS-1, else increment n; otherwise increment s.
REQ-018 SHALL, in STOP on s_tick with s==STOP_BIT_TICKS-1, load rx_dout from shift register, pulse rx_done_tick, pulse frame_err if rx_s==0, go to IDLE; otherwise increment s.
REQ-019 SHALL size s to hold STOP_BIT_TICKS-1 without wrap (5 bits when STOP_BIT_TICKS>16).
REQ-020 SHALL hold rx_dout unchanged between completions; rx_dout SHALL update even on frame error.
REQ-021 SHALL accept a new start bit immediately after returning to IDLE (back-to-back frames, zero idle gap).

Reset
REQ-022 SHALL on reset_n low, at any time including mid-frame, force IDLE, s=0, n=0, shift register 0, rx_dout 0, rx_done_tick/frame_err/parity_err 0, busy 0, synchronizer flops 1.
REQ-023 SHALL produce no rx_done_tick for a frame interrupted by reset.

Configuration
REQ-024 SHALL, with UART_RX_PARITY_EN defined, insert PARITY after DATA: on s_tick with s==15 sample rx_s, set s=0, go to STOP; parity_err pulses with rx_done_tick if XOR(data, parity bit) != PARITY_ODD.
REQ-025 SHALL, without UART_RX_PARITY_EN, omit the PARITY state, parity_err port and parity logic; DATA goes directly to STOP.

Verification
REQ-026 SHALL cover: frame 0xA5, 8N1, 16 ticks/bit -> rx_dout=0xA5, exactly one rx_done_tick, frame_err=0.
REQ-027 SHALL cover: rx low for 4 ticks then high -> no rx_done_tick, busy returns 0 within 8 ticks, rx_dout unchanged.
REQ-028 SHALL cover: data 0x3C with stop bit low -> rx_dout=0x3C, rx_done_tick and frame_err high in the same cycle.
REQ-029 SHALL cover: 0x00 then 0xFF back-to-back with no idle gap -> two rx_done_ticks, rx_dout 0x00 then 0xFF.
REQ-030 SHALL cover: reset_n pulsed low during data bit 3 -> all outputs at reset values, no done pulse; next frame 0x5A received correctly.
REQ-031 SHALL cover (macro defined, PARITY_ODD=0): data 0x07 with parity bit 0 -> parity_err=1; parity bit 1 -> parity_err=0.
